wb_data_mem: RTL
================

Name: wb_data_mem

Overview:
- Wishbone-style single-port data/instruction memory; the responder to the CPU's memory initiator port.
- Byte-addressed, little-endian, backed by a 32-bit word array.
- Decodes the RV32 funct3 size/sign code presented on sel into byte/half/word loads and stores, with sign/zero extension on reads.
- Asserts stall while a request is in flight and returns a single-cycle ack after a configurable latency.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; must be a power of two. AW = log2(DEPTH_WORDS).
- LATENCY, 1: extra wait cycles between request capture and ack (0..15).
- INIT_FILE, "": if non-empty, the word array is loaded with $readmemh at elaboration.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_wb_stb  in  1  request strobe.
- i_wb_we  in  1  1 = write, 0 = read.
- i_wb_addr  in  32  byte address.
- i_wb_data  in  32  write data, right-justified.
- i_wb_sel  in  3  funct3 code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- o_wb_data  out  32  read data, valid while o_wb_ack=1.
- o_wb_ack  out  1  one-cycle completion pulse.
- o_wb_stall  out  1  busy; new requests are not accepted while high.
- o_misaligned  out  1  pulses with o_wb_ack when the request was misaligned or illegal.

Behaviour:
- Reset: clock i_clk; reset i_reset, synchronous, active-high.
  - Reset drives o_wb_ack=0, o_wb_stall=0, o_misaligned=0, o_wb_data=0, state=IDLE, counter=0.
  - Memory contents are not cleared.
- States: IDLE, WAIT, RESP.
- Acceptance in IDLE: i_wb_stb=1 and o_wb_stall=0 sampled at edge T.
  - Latch addr, we, sel and data.
  - Set o_wb_stall=1 from cycle T+1.
  - If LATENCY=0, go to RESP; otherwise go to WAIT with counter=LATENCY-1.
- WAIT: decrement the counter each cycle; when counter==0, go to RESP.
- RESP (cycle T+1+LATENCY):
  - o_wb_ack=1 for exactly one cycle; o_wb_stall stays 1.
  - A write commits to the array at the edge that enters RESP.
  - Next state is IDLE. o_wb_stall=0 and o_wb_ack=0 from cycle T+2+LATENCY.
  - Earliest back-to-back acceptance is at edge T+2+LATENCY.
- i_wb_stb while stall=1 (WAIT or RESP) is ignored. An initiator holding stb high until ack therefore issues one transaction only.
- Word index = addr[AW+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
- Read lanes:
  - Byte: lane addr[1:0]; sel[2]=0 sign-extends bit 7, sel[2]=1 zero-extends.
  - Half: lane addr[1]; sign/zero extension from bit 15 by sel[2].
  - Word: full word.
- Write lanes:
  - Byte: i_wb_data[7:0] into lane addr[1:0]; other bytes untouched.
  - Half: i_wb_data[15:0] into lane addr[1].
  - Word: full word.
  - sel[2] is ignored for writes.
- Misaligned or illegal requests: half with addr[0]=1, word with addr[1:0]≠0, sel ∈ {011, 110, 111}, or a write with sel[2]=1.
  - Still acked with normal timing and o_misaligned=1 in the ack cycle.
  - Reads return 0; writes are not committed.
- o_wb_data: on a read ack it carries the extracted value; on a write ack it is 0; it holds its value otherwise.
- Reset mid-transaction (WAIT or RESP): the transaction is abandoned, no ack is produced, and the state returns to IDLE. A write is not committed unless its commit edge already passed.

Test Plan:
1. Word write then read, LATENCY=1: SW 0xDEADBEEF @0x10 → ack at T+2, stall high T+1..T+2. LW @0x10 → o_wb_data=0xDEADBEEF.
2. Byte/half extension: word @0x20=0x80FF7F01.
   - LB @0x22 → 0xFFFFFFFF; LBU @0x23 → 0x00000080.
   - LH @0x22 → 0xFFFF80FF; LHU @0x20 → 0x00007F01.
3. Partial writes: word @0x30=0x11223344, SB 0xAA @0x31 → word 0x1122AA44; SH 0xBEEF @0x32 → word 0xBEEFAA44.
4. Stall/hold: stb held high through WAIT and RESP → exactly one ack. A second stb in the ack cycle is ignored; a new stb at ack+1 is accepted.
5. Misaligned: LW @0x11 → ack with o_misaligned=1, data=0. SH @0x33 → ack with o_misaligned=1, memory unchanged. sel=011 → o_misaligned=1.
6. Reset mid-op (LATENCY=3): SW 0x12345678 @0x40, reset during WAIT → no ack, stall=0, word @0x40 unchanged. LATENCY=0: ack at T+1. Wrap: SW @(4*DEPTH_WORDS+8) → readable @0x8.

Source files
------------

// File: rtl/wb_data_mem.sv
// Wishbone-style byte-addressed data memory with RV32 funct3 load/store decode,
// configurable ack latency and misaligned/illegal request flagging.
module wb_data_mem #(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    LATENCY     = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic [2:0]  i_wb_sel,
  output logic [31:0] o_wb_data,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic        o_misaligned
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  localparam logic [3:0] LAT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic [AW+1:0] r_addr;
  logic          r_we;
  logic [2:0]    r_sel;
  logic [31:0]   r_data;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic          w_go_resp;
  logic [AW+1:0] w_addr;
  logic          w_we;
  logic [2:0]    w_sel;
  logic [31:0]   w_data;
  logic          w_illegal;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rd_word;
  logic [31:0]   w_load;
  logic [31:0]   w_store;
  logic          w_mem_we;
  logic          w_unused_addr;

  function automatic logic f_illegal(input logic we, input logic [2:0] sel, input logic [1:0] lo);
    logic bad;
    case (sel)
      3'b000:  bad = 1'b0;
      3'b001:  bad = lo[0];
      3'b010:  bad = (lo != 2'b00);
      3'b100:  bad = we;
      3'b101:  bad = we | lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] f_load(input logic [31:0] word, input logic [1:0] lo, input logic [2:0] sel);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] v;
    case (lo)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (sel[1:0])
      2'b00:   v = {{24{b[7] & ~sel[2]}}, b};
      2'b01:   v = {{16{h[15] & ~sel[2]}}, h};
      2'b10:   v = word;
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] f_store(input logic [31:0] old, input logic [31:0] d,
                                          input logic [1:0] lo, input logic [1:0] size);
    logic [31:0] v;
    v = old;
    case (size)
      2'b00: begin
        case (lo)
          2'b00:   v[7:0]   = d[7:0];
          2'b01:   v[15:8]  = d[7:0];
          2'b10:   v[23:16] = d[7:0];
          default: v[31:24] = d[7:0];
        endcase
      end
      2'b01: begin
        if (lo[1]) v[31:16] = d[15:0];
        else       v[15:0]  = d[15:0];
      end
      2'b10:   v = d;
      default: v = old;
    endcase
    return v;
  endfunction

  // In IDLE the live bus is used so a zero-latency request can complete at its accept edge.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_addr = i_wb_addr[AW+1:0];
      w_we   = i_wb_we;
      w_sel  = i_wb_sel;
      w_data = i_wb_data;
    end else begin
      w_addr = r_addr;
      w_we   = r_we;
      w_sel  = r_sel;
      w_data = r_data;
    end
  end

  assign w_unused_addr = ^i_wb_addr[31:AW+2];
  assign w_accept      = (r_state == S_IDLE) && i_wb_stb && !o_wb_stall;
  assign w_go_resp     = (w_accept && (LATENCY == 0)) || ((r_state == S_WAIT) && (r_cnt == 4'd0));
  assign w_illegal     = f_illegal(w_we, w_sel, w_addr[1:0]);
  assign w_idx         = w_addr[AW+1:2];
  assign w_rd_word     = r_mem[w_idx];
  assign w_load        = f_load(w_rd_word, w_addr[1:0], w_sel);
  assign w_store       = f_store(w_rd_word, w_data, w_addr[1:0], w_sel[1:0]);
  assign w_mem_we      = w_go_resp && w_we && !w_illegal && !i_reset;

  // Request FSM plus registered bus responses.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      o_wb_ack     <= 1'b0;
      o_wb_stall   <= 1'b0;
      o_misaligned <= 1'b0;
      o_wb_data    <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr     <= w_addr;
            r_we       <= i_wb_we;
            r_sel      <= i_wb_sel;
            r_data     <= i_wb_data;
            r_cnt      <= LAT_LOAD;
            o_wb_stall <= 1'b1;
            r_state    <= (LATENCY == 0) ? S_RESP : S_WAIT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) r_state <= S_RESP;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_RESP: begin
          r_state    <= S_IDLE;
          o_wb_stall <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          o_wb_stall <= 1'b0;
        end
      endcase
      o_wb_ack <= w_go_resp;
      if (w_go_resp) begin
        o_misaligned <= w_illegal;
        o_wb_data    <= (w_we || w_illegal) ? 32'd0 : w_load;
      end else begin
        o_misaligned <= 1'b0;
      end
    end
  end

  // Word array; a write lands on the edge that enters RESP.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) r_mem[w_idx] <= w_store;
  end

endmodule
